data_unpack: RTL and testbench
==============================

Name: data_unpack

Overview:
Reverse of the activation packer. Reads 64-bit packed activation words from the layer output RAM and streams them out as 16-bit activations, one per handshake, for the next layer's MAC array. Lane order matches the packer: lane 0 = bits [63:48], lane 3 = bits [15:0]. A start pulse launches each burst of a given length; a done pulse ends it.

Parameters:
ADDR_W, 10, RAM word address width
CNT_W, 10, width of word_cnt (max burst length in 64-bit words)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that launches a burst; ignored unless idle
base_addr  in  ADDR_W  first RAM word address, sampled on start
word_cnt  in  CNT_W  number of 64-bit words in the burst, sampled on start
ram_rd_en  out  1  RAM read strobe
ram_rd_addr  out  ADDR_W  RAM read address
ram_rd_data  in  64  RAM read data, valid exactly 1 cycle after ram_rd_en
dout  out  16  current activation
dout_valid  out  1  dout holds a valid activation
dout_ready  in  1  consumer accepts dout this cycle
dout_last  out  1  high with dout_valid on the final activation of the burst
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at burst end

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal address, word count, lane counter and word register cleared. A reset mid-burst aborts the burst immediately; no done pulse is issued.
- FSM states: IDLE, REQ, WAIT, SEND, DONE.
- IDLE: when start=1, latch base_addr into addr and word_cnt into words_left.
  - If word_cnt==0, go to DONE.
  - Otherwise go to REQ.
- REQ: ram_rd_en=1 and ram_rd_addr=addr for exactly one cycle, then go to WAIT.
- WAIT: capture ram_rd_data into word_reg at the end of the cycle. Set lane=0 and go to SEND.
- SEND: dout_valid=1 and dout=word_reg lane slice (lane 0 = [63:48] … lane 3 = [15:0]).
  - dout and dout_valid stay stable until dout_ready=1.
  - Transfer occurs on dout_valid && dout_ready.
  - On a transfer with lane<3: lane increments and the next lane is presented in the following cycle.
  - On a transfer with lane==3 and words_left>1: decrement words_left, set addr=addr+1 (mod 2^ADDR_W), go to REQ.
  - On a transfer with lane==3 and words_left==1: go to DONE.
- dout_last = dout_valid && lane==3 && words_left==1.
- DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE, including DONE.
- Latency: start in cycle 0 → ram_rd_en in cycle 1 → first dout_valid in cycle 3.
  - With dout_ready tied high, each word occupies 6 cycles (REQ, WAIT, 4×SEND).
  - Throughput is therefore 4 activations per 6 cycles. No prefetch.
- start while busy: ignored, with no effect on the latched parameters.
- start in the same cycle as DONE: ignored. It is only accepted in IDLE.
- The block performs no ReLU or sign handling. Data passes through bit-exact, so negative values are legal.
- dout reads 0 whenever dout_valid=0.

Decomposition:
- Shared package holds:
  - WORD_W=64, ACT_W=16, LANES=4
  - the state encoding constants for IDLE/REQ/WAIT/SEND/DONE
  - the lane-to-bit-slice convention, shared with the packer so lane order cannot diverge
- One sub-module: unpack_lane_sel. It is a combinational 4:1 mux taking word_reg and lane and returning the 16-bit slice per the package convention.
- FSM, counters and handshake stay in data_unpack.

Test Plan:
- Single word, ready tied high: base_addr=5, word_cnt=1, RAM[5]=64'h1111_2222_3333_4444 → ram_rd_addr=5 in cycle 1; dout 1111,2222,3333,4444 in cycles 3–6; dout_last only with 4444; done in cycle 7; busy low in cycle 8.
- Multi-word with address wrap: ADDR_W=10, base_addr=1023, word_cnt=2, RAM[1023]=64'hA..., RAM[0]=64'hB... → reads at 1023 then 0; 8 activations in order; a single done pulse.
- Backpressure: dout_ready low for 3 cycles while dout=2222 → dout and dout_valid held stable; no RAM read issued; lane advances only on the ready cycle.
- Zero-length burst: start with word_cnt=0 → no ram_rd_en; done in cycle 1; dout_valid never asserted.
- start while busy: second start with base_addr=100 mid-burst → ignored; the burst finishes from the original addresses; exactly one done.
- Reset mid-burst: rst during SEND of lane 2 → next cycle all outputs 0 and busy=0; no done; a fresh start behaves as in scenario 1.

Source files
------------

// File: rtl/data_unpack_pkg.sv
// Shared definitions for the activation unpacker: word/activation geometry,
// FSM state encoding and the lane-to-bit-slice convention shared with the packer.
package data_unpack_pkg;

    localparam int WORD_W = 64;
    localparam int ACT_W  = 16;
    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Lane 0 is the most significant activation, matching the packer's fill order.
    function automatic logic [ACT_W-1:0] lane_slice(input logic [WORD_W-1:0] word,
                                                    input logic [LANE_W-1:0] lane);
        logic [ACT_W-1:0] slice_s;
        case (lane)
            2'd0:    slice_s = word[63:48];
            2'd1:    slice_s = word[47:32];
            2'd2:    slice_s = word[31:16];
            2'd3:    slice_s = word[15:0];
            default: slice_s = word[15:0];
        endcase
        return slice_s;
    endfunction

endpackage

// File: rtl/data_unpack_lane_sel.sv
// Combinational 4:1 activation selector from a packed 64-bit word.
module unpack_lane_sel
    import data_unpack_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic [ACT_W-1:0]  act_o
);

    assign act_o = lane_slice(word_i, lane_i);

endmodule

// File: rtl/data_unpack.sv
// Streams 64-bit packed activation words from RAM as 16-bit activations,
// one word fetch at a time (no prefetch), with valid/ready handshake.
module data_unpack
    import data_unpack_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [WORD_W-1:0] ram_rd_data,
    output logic [ACT_W-1:0]  dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    words_left_q, words_left_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0]   word_q, word_d;

    logic                ram_rd_en_q;
    logic [ADDR_W-1:0]   ram_rd_addr_q;
    logic                dout_valid_q;
    logic                dout_last_q;
    logic                busy_q;
    logic                done_q;
    logic [ACT_W-1:0]    act_s;

    // Next-state and datapath update for the burst FSM
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        lane_d       = lane_q;
        word_d       = word_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    words_left_d = word_cnt;
                    if (word_cnt == {CNT_W{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                word_d  = ram_rd_data;
                lane_d  = {LANE_W{1'b0}};
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (dout_ready) begin
                    if (lane_q != LANE_W'(LANES - 1)) begin
                        lane_d = lane_q + LANE_W'(1);
                    end else if (words_left_q > CNT_W'(1)) begin
                        words_left_d = words_left_q - CNT_W'(1);
                        addr_d       = addr_q + ADDR_W'(1);
                        state_d      = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; outputs are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= {ADDR_W{1'b0}};
            words_left_q  <= {CNT_W{1'b0}};
            lane_q        <= {LANE_W{1'b0}};
            word_q        <= {WORD_W{1'b0}};
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= {ADDR_W{1'b0}};
            dout_valid_q  <= 1'b0;
            dout_last_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            words_left_q  <= words_left_d;
            lane_q        <= lane_d;
            word_q        <= word_d;
            ram_rd_en_q   <= (state_d == ST_REQ);
            ram_rd_addr_q <= (state_d == ST_REQ) ? addr_d : {ADDR_W{1'b0}};
            dout_valid_q  <= (state_d == ST_SEND);
            dout_last_q   <= (state_d == ST_SEND) && (lane_d == LANE_W'(LANES - 1))
                             && (words_left_d == CNT_W'(1));
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE);
        end
    end

    unpack_lane_sel u_lane_sel (
        .word_i (word_q),
        .lane_i (lane_q),
        .act_o  (act_s)
    );

    assign ram_rd_en   = ram_rd_en_q;
    assign ram_rd_addr = ram_rd_addr_q;
    assign dout        = dout_valid_q ? act_s : {ACT_W{1'b0}};
    assign dout_valid  = dout_valid_q;
    assign dout_last   = dout_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_data_unpack.sv
// Self-checking bench for data_unpack: queue-based activation/address model
// plus directed scenarios with literal cycle-accurate expectations.
module tb_data_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = 10'd0;
    logic [9:0]  word_cnt = 10'd0;
    logic        ram_rd_en;
    logic [9:0]  ram_rd_addr;
    logic [63:0] ram_rd_data = 64'd0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        dout_last;
    logic        busy;
    logic        done;

    logic [63:0] mem [0:1023];
    logic [16:0] exp_act[$];
    logic [9:0]  exp_addr[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          done_seen = 0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_dout = 16'd0;

    data_unpack #(.ADDR_W(10), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected reads and activations of an accepted burst
    task automatic push_burst(input logic [9:0] base, input int cnt);
        logic [9:0]  a;
        logic [63:0] w;
        for (int k = 0; k < cnt; k++) begin
            a = base + 10'(k);
            exp_addr.push_back(a);
            w = mem[a];
            for (int l = 0; l < 4; l++) begin
                exp_act.push_back({16'(w >> (48 - 16 * l)), (k == cnt - 1) && (l == 3)});
            end
        end
    endtask

    // Pulse start during cycle 0; returns 2 time units into cycle 1
    task automatic start_burst(input logic [9:0] base, input logic [9:0] cnt);
        @(posedge clk); #2;
        base_addr = base; word_cnt = cnt; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_seen;
        int k = 0;
        while (done_seen == d0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_within_budget", 64'(done_seen != d0), 64'd1);
    endtask

    // Model comparison on every cycle, sampled on the falling edge
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (dout_valid) begin
                if (prev_hold) chk("hold_dout", 64'(dout), 64'(prev_dout));
                chk("act_expected", 64'(exp_act.size() > 0), 64'd1);
                if (exp_act.size() > 0) begin
                    e = exp_act[0];
                    chk("dout", 64'(dout), 64'(e[16:1]));
                    chk("dout_last", 64'(dout_last), 64'(e[0]));
                    if (dout_ready) void'(exp_act.pop_front());
                end
            end else begin
                if (prev_hold) chk("hold_valid", 64'(dout_valid), 64'd1);
                chk("idle_dout_zero", 64'({dout_last, dout}), 64'd0);
            end
            prev_hold = dout_valid && !dout_ready;
            prev_dout = dout;
            if (ram_rd_en) begin
                chk("read_expected", 64'(exp_addr.size() > 0), 64'd1);
                if (exp_addr.size() > 0) chk("ram_rd_addr", 64'(ram_rd_addr), 64'(exp_addr.pop_front()));
            end
            if (done) begin
                done_seen++;
                chk("done_drained", 64'(exp_act.size() + exp_addr.size()), 64'd0);
            end
        end
    end

    // Single word, ready high, literal cycle-by-cycle expectations
    task automatic run_single(input logic [9:0] base);
        logic [15:0] lits [4];
        int d0;
        lits[0] = 16'h1111; lits[1] = 16'h2222; lits[2] = 16'h3333; lits[3] = 16'h4444;
        mem[base] = 64'h1111_2222_3333_4444;
        d0 = done_seen;
        push_burst(base, 1);
        start_burst(base, 10'd1);
        @(negedge clk);
        chk("c1_rd_en", 64'(ram_rd_en), 64'd1);
        chk("c1_rd_addr", 64'(ram_rd_addr), 64'(base));
        chk("c1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("c2_valid", 64'(dout_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("c3_6_valid", 64'(dout_valid), 64'd1);
            chk("c3_6_dout", 64'(dout), 64'(lits[i]));
            chk("c3_6_last", 64'(dout_last), 64'(i == 3));
        end
        @(negedge clk);
        chk("c7_done", 64'(done), 64'd1);
        chk("c7_busy", 64'(busy), 64'd1);
        @(negedge clk); #1;
        chk("c8_busy", 64'(busy), 64'd0);
        chk("c8_done", 64'(done), 64'd0);
        chk("single_done_count", 64'(done_seen - d0), 64'd1);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 1024; i++) mem[i] = {48'd0, 16'(i)} ^ 64'hC0DE_0000_0000_0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 64'({ram_rd_en, ram_rd_addr, dout, dout_valid, dout_last, busy, done}), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Scenario 1
        run_single(10'd5);

        // Multi-word burst wrapping from 1023 to 0
        mem[1023] = 64'hA1A1_A2A2_A3A3_A4A4;
        mem[0]    = 64'hB1B1_B2B2_B3B3_B4B4;
        d0 = done_seen;
        push_burst(10'd1023, 2);
        chk("model_first_act", 64'(exp_act[0]), {47'd0, 16'hA1A1, 1'b0});
        chk("model_last_act", 64'(exp_act[7]), {47'd0, 16'hB4B4, 1'b1});
        chk("model_wrap_addr", 64'(exp_addr[1]), 64'd0);
        start_burst(10'd1023, 10'd2);
        wait_done(40);
        repeat (3) @(negedge clk);
        chk("wrap_done_count", 64'(done_seen - d0), 64'd1);

        // Backpressure while 2222 is presented
        mem[7] = 64'h1111_2222_3333_4444;
        push_burst(10'd7, 1);
        start_burst(10'd7, 10'd1);
        repeat (3) @(posedge clk);
        #2 dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(dout_valid), 64'd1);
            chk("bp_dout", 64'(dout), 64'h2222);
            chk("bp_no_read", 64'(ram_rd_en), 64'd0);
        end
        @(posedge clk); #2 dout_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_dout", 64'(dout), 64'h2222);
        @(negedge clk);
        chk("bp_next_dout", 64'(dout), 64'h3333);
        wait_done(20);

        // Zero-length burst
        d0 = done_seen;
        start_burst(10'd9, 10'd0);
        @(negedge clk);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_no_read", 64'(ram_rd_en), 64'd0);
        @(negedge clk); #1;
        chk("zero_idle", 64'({busy, done, dout_valid}), 64'd0);
        chk("zero_done_count", 64'(done_seen - d0), 64'd1);

        // Start while busy, and start coinciding with DONE, are both ignored
        mem[20] = 64'h8000_7FFF_FFFF_0001;
        mem[21] = 64'h0123_4567_89AB_CDEF;
        d0 = done_seen;
        push_burst(10'd20, 2);
        start_burst(10'd20, 10'd2);
        repeat (3) @(posedge clk);
        #2 base_addr = 10'd100; word_cnt = 10'd5; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 base_addr = 10'd0; word_cnt = 10'd1; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ignored_start_idle", 64'(busy), 64'd0);
        end
        #1 chk("busy_start_done_count", 64'(done_seen - d0), 64'd1);

        // Reset during lane 2 of a burst
        mem[5] = 64'h1111_2222_3333_4444;
        d0 = done_seen;
        push_burst(10'd5, 1);
        start_burst(10'd5, 10'd1);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", 64'({ram_rd_en, ram_rd_addr, dout, dout_valid, dout_last, busy, done}), 64'd0);
        exp_act.delete();
        exp_addr.delete();
        repeat (4) @(negedge clk);
        #1 chk("midrst_no_done", 64'(done_seen - d0), 64'd0);
        run_single(10'd5);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
